// File: rtl/seg_execute_pkg.sv
// Shared encodings for the execute stage: ALU codes, mul/div opcodes,
// forwarding selects and the mul/div sequencer states.
package seg_execute_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MFHI  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;
  localparam logic [2:0] MD_MT    = 3'b111;

  localparam logic [1:0] FWD_RD1 = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_e;

endpackage

// File: rtl/seg_execute_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (one bit per RUN cycle).
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the multiplier is exhausted.
module seg_execute_muldiv_unit
  import seg_execute_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_is_div,
  input  logic           i_signed,
  input  logic           i_mt_we,
  input  logic           i_mt_lo,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic [LEN-1:0] o_hi,
  output logic [LEN-1:0] o_lo,
  output logic           o_busy
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             div0_q, div0_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  // mul: acc = partial product, opa = shifted multiplicand, opb = multiplier
  // div: acc[LEN-1:0] = remainder, opa[LEN-1:0] = divisor, opb = dividend -> quotient
  logic [2*LEN-1:0] acc_q, acc_d;
  logic [2*LEN-1:0] opa_q, opa_d;
  logic [LEN-1:0]   opb_q, opb_d;
  logic [LEN-1:0]   hi_q, hi_d;
  logic [LEN-1:0]   lo_q, lo_d;

  logic             a_neg, b_neg, ge, last_run;
  logic [LEN-1:0]   a_mag, b_mag, quo, rem;
  logic [LEN:0]     trial, diff;
  logic [2*LEN-1:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_neg = i_signed & i_a[LEN-1];
    b_neg = i_signed & i_b[LEN-1];
    a_mag = a_neg ? -i_a : i_a;
    b_mag = b_neg ? -i_b : i_b;

    trial = {acc_q[LEN-1:0], opb_q[LEN-1]};
    ge    = trial >= {1'b0, opa_q[LEN-1:0]};
    diff  = trial - {1'b0, opa_q[LEN-1:0]};
    prod  = qneg_q ? -acc_q : acc_q;
    quo   = qneg_q ? -opb_q : opb_q;
    rem   = rneg_q ? -acc_q[LEN-1:0] : acc_q[LEN-1:0];

`ifdef MULDIV_EARLY_OUT_EN
    last_run = (cnt_q == CNT_LAST) || (!is_div_q && (opb_q >> 1) == '0);
`else
    last_run = (cnt_q == CNT_LAST);
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = i_is_div;
          div0_d   = (i_b == '0);
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          acc_d    = '0;
          opa_d    = {{LEN{1'b0}}, (i_is_div ? b_mag : a_mag)};
          opb_d    = i_is_div ? a_mag : b_mag;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = {{LEN{1'b0}}, (ge ? diff[LEN-1:0] : trial[LEN-1:0])};
          opb_d = {opb_q[LEN-2:0], ge};
        end else begin
          acc_d = acc_q + (opb_q[0] ? opa_q : '0);
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
        if (last_run) state_d = FIX;
      end
      FIX: begin
        // Divide by zero yields all-ones quotient; the remainder path already
        // reconstructs the original dividend.
        if (is_div_q) begin
          hi_d = rem;
          lo_d = div0_q ? '1 : quo;
        end else begin
          hi_d = prod[2*LEN-1:LEN];
          lo_d = prod[LEN-1:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_mt_we) begin
      if (i_mt_lo) lo_d = i_a;
      else         hi_d = i_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    o_hi   = hi_q;
    o_lo   = lo_q;
    o_busy = (state_q != IDLE);
  end

endmodule

// File: rtl/seg_execute_muldiv.sv
// MIPS execute stage: forwarding, ALU, HI/LO result mux and EX/MEM register.
// Build option MULDIV_EARLY_OUT_EN is consumed by seg_execute_muldiv_unit.
module seg_execute_muldiv
  import seg_execute_pkg::*;
#(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 9,
  parameter int NB_ALUCTL  = 4,
  parameter int NB_MDOP    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [LEN-1:0]        i_PC,
  input  logic [LEN-1:0]        i_read_data_1,
  input  logic [LEN-1:0]        i_read_data_2,
  input  logic [LEN-1:0]        i_imm_ext,
  input  logic [NB_ADDR-1:0]    i_rt,
  input  logic [NB_ADDR-1:0]    i_rd,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_ALUCTL-1:0]  i_alu_ctl,
  input  logic                  i_alu_src,
  input  logic                  i_reg_dst,
  input  logic [NB_MDOP-1:0]    i_md_op,
  input  logic [1:0]            i_fwd_a,
  input  logic [1:0]            i_fwd_b,
  input  logic [LEN-1:0]        i_fwd_mem,
  input  logic [LEN-1:0]        i_fwd_wb,
  output logic                  o_valid,
  output logic [LEN-1:0]        o_PC_branch,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [LEN-1:0]        o_write_data,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic                  o_ALU_zero,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic                  o_stall,
  output logic                  o_busy
);

  logic [LEN-1:0] opa, fwd_b, opb, alu_res, ex_res, hi, lo;
  logic           md_busy, accept, md_start, md_div, md_signed, mt_we;
  logic           op_mul, op_div;

  logic                  valid_q, valid_d;
  logic [LEN-1:0]        pc_br_q, pc_br_d;
  logic [LEN-1:0]        res_q, res_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic [NB_ADDR-1:0]    wreg_q, wreg_d;
  logic                  zero_q, zero_d;
  logic [NB_CTRL_WB-1:0] cwb_q, cwb_d;
  logic [NB_CTRL_M-1:0]  cm_q, cm_d;

  always_comb begin
    case (i_fwd_a)
      FWD_MEM: opa = i_fwd_mem;
      FWD_WB:  opa = i_fwd_wb;
      FWD_RD1: opa = i_read_data_1;
      default: opa = i_read_data_1;
    endcase
    case (i_fwd_b)
      FWD_MEM: fwd_b = i_fwd_mem;
      FWD_WB:  fwd_b = i_fwd_wb;
      FWD_RD1: fwd_b = i_read_data_2;
      default: fwd_b = i_read_data_2;
    endcase
    opb = i_alu_src ? i_imm_ext : fwd_b;
  end

  always_comb begin
    case (i_alu_ctl)
      NB_ALUCTL'(ALU_AND): alu_res = opa & opb;
      NB_ALUCTL'(ALU_OR):  alu_res = opa | opb;
      NB_ALUCTL'(ALU_ADD): alu_res = opa + opb;
      NB_ALUCTL'(ALU_SUB): alu_res = opa - opb;
      NB_ALUCTL'(ALU_SLT): alu_res = {{(LEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      NB_ALUCTL'(ALU_NOR): alu_res = ~(opa | opb);
      default:             alu_res = '0;
    endcase
  end

  // Only HI/LO-touching instructions wait on the unit; everything else flows.
  always_comb begin
    op_mul    = (i_md_op == NB_MDOP'(MD_MULT)) | (i_md_op == NB_MDOP'(MD_MULTU));
    op_div    = (i_md_op == NB_MDOP'(MD_DIV))  | (i_md_op == NB_MDOP'(MD_DIVU));
    o_stall   = i_valid & md_busy & (i_md_op != NB_MDOP'(MD_NONE));
    accept    = i_valid & ~o_stall & ~i_flush;
    md_start  = accept & (op_mul | op_div);
    md_div    = op_div;
    md_signed = (i_md_op == NB_MDOP'(MD_MULT)) | (i_md_op == NB_MDOP'(MD_DIV));
    mt_we     = accept & (i_md_op == NB_MDOP'(MD_MT));

    case (i_md_op)
      NB_MDOP'(MD_MFHI):  ex_res = hi;
      NB_MDOP'(MD_MFLO):  ex_res = lo;
      NB_MDOP'(MD_MULT),
      NB_MDOP'(MD_MULTU),
      NB_MDOP'(MD_DIV),
      NB_MDOP'(MD_DIVU),
      NB_MDOP'(MD_MT):    ex_res = '0;
      default:            ex_res = alu_res;
    endcase
  end

  seg_execute_muldiv_unit #(
    .LEN(LEN)
  ) u_muldiv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (md_start),
    .i_is_div(md_div),
    .i_signed(md_signed),
    .i_mt_we (mt_we),
    .i_mt_lo (i_imm_ext[0]),
    .i_a     (opa),
    .i_b     (fwd_b),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_busy  (md_busy)
  );

  // Rejected cycles insert a bubble: valid and control cleared, data held.
  always_comb begin
    valid_d = accept;
    pc_br_d = pc_br_q;
    res_d   = res_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    zero_d  = zero_q;
    cwb_d   = '0;
    cm_d    = '0;
    if (accept) begin
      pc_br_d = i_PC + (i_imm_ext << 2);
      res_d   = ex_res;
      wdata_d = fwd_b;
      wreg_d  = i_reg_dst ? i_rd : i_rt;
      zero_d  = (ex_res == '0);
      cwb_d   = i_ctrl_wb_bus;
      cm_d    = i_ctrl_mem_bus;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_q <= 1'b0;
      pc_br_q <= '0;
      res_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      zero_q  <= 1'b0;
      cwb_q   <= '0;
      cm_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_br_q <= pc_br_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      zero_q  <= zero_d;
      cwb_q   <= cwb_d;
      cm_q    <= cm_d;
    end
  end

  always_comb begin
    o_valid          = valid_q;
    o_PC_branch      = pc_br_q;
    o_ALU_result     = res_q;
    o_write_data     = wdata_q;
    o_write_register = wreg_q;
    o_ALU_zero       = zero_q;
    o_ctrl_wb_bus    = cwb_q;
    o_ctrl_mem_bus   = cm_q;
    o_busy           = md_busy;
  end

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// Randomized self-checking bench for seg_execute_muldiv against a behavioural model.
module tb_seg_execute_muldiv;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_DIVU = 3'd4, OP_MFHI = 3'd5, OP_MFLO = 3'd6, OP_MT = 3'd7;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_alu_src, i_reg_dst;
  logic [31:0] i_PC, i_read_data_1, i_read_data_2, i_imm_ext, i_fwd_mem, i_fwd_wb;
  logic [4:0]  i_rt, i_rd;
  logic [1:0]  i_ctrl_wb_bus, i_fwd_a, i_fwd_b;
  logic [8:0]  i_ctrl_mem_bus;
  logic [3:0]  i_alu_ctl;
  logic [2:0]  i_md_op;
  logic        o_valid, o_ALU_zero, o_stall, o_busy;
  logic [31:0] o_PC_branch, o_ALU_result, o_write_data;
  logic [4:0]  o_write_register;
  logic [1:0]  o_ctrl_wb_bus;
  logic [8:0]  o_ctrl_mem_bus;

  int vectors = 0;
  int errors  = 0;

  always #5 i_clk = ~i_clk;

  seg_execute_muldiv #(
    .LEN(32), .NB_ADDR(5), .NB_CTRL_WB(2), .NB_CTRL_M(9), .NB_ALUCTL(4), .NB_MDOP(3)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush), .i_PC(i_PC),
    .i_read_data_1(i_read_data_1), .i_read_data_2(i_read_data_2), .i_imm_ext(i_imm_ext),
    .i_rt(i_rt), .i_rd(i_rd), .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_ctrl_mem_bus(i_ctrl_mem_bus),
    .i_alu_ctl(i_alu_ctl), .i_alu_src(i_alu_src), .i_reg_dst(i_reg_dst), .i_md_op(i_md_op),
    .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b), .i_fwd_mem(i_fwd_mem), .i_fwd_wb(i_fwd_wb),
    .o_valid(o_valid), .o_PC_branch(o_PC_branch), .o_ALU_result(o_ALU_result),
    .o_write_data(o_write_data), .o_write_register(o_write_register), .o_ALU_zero(o_ALU_zero),
    .o_ctrl_wb_bus(o_ctrl_wb_bus), .o_ctrl_mem_bus(o_ctrl_mem_bus), .o_stall(o_stall),
    .o_busy(o_busy)
  );

  function automatic logic [31:0] fwd_sel(input logic [1:0] s, input logic [31:0] rd, mem, wb);
    if (s == 2'b01) return mem;
    if (s == 2'b10) return wb;
    return rd;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  return 64'd0;
    endcase
  endfunction

  // Cycles the unit stays busy after accepting op.
  function automatic int md_busy(input logic [2:0] op, input logic [31:0] b);
    int run;
    run = 32;
`ifdef MULDIV_EARLY_OUT_EN
    if (op == OP_MULT || op == OP_MULTU) begin
      logic [31:0] m;
      m = (op == OP_MULT && b[31]) ? -b : b;
      run = 1;
      for (int i = 0; i < 32; i++) if (m[i]) run = i + 1;
    end
`endif
    return run + 1;
  endfunction

  task automatic idle_inputs();
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_PC = '0; i_read_data_1 = '0;
    i_read_data_2 = '0; i_imm_ext = '0; i_rt = '0; i_rd = '0; i_ctrl_wb_bus = '0;
    i_ctrl_mem_bus = '0; i_alu_ctl = '0; i_alu_src = 1'b0; i_reg_dst = 1'b0;
    i_md_op = OP_NONE; i_fwd_a = '0; i_fwd_b = '0; i_fwd_mem = '0; i_fwd_wb = '0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_ops(input logic [31:0] a, b);
    i_fwd_a = 2'($urandom_range(0, 3));
    i_fwd_b = 2'($urandom_range(0, 3));
    if (i_fwd_b == i_fwd_a && (i_fwd_a == 2'b01 || i_fwd_a == 2'b10)) i_fwd_b = 2'b00;
    i_read_data_1 = $urandom; i_read_data_2 = $urandom; i_fwd_mem = $urandom; i_fwd_wb = $urandom;
    case (i_fwd_a)
      2'b01:   i_fwd_mem = a;
      2'b10:   i_fwd_wb = a;
      default: i_read_data_1 = a;
    endcase
    case (i_fwd_b)
      2'b01:   i_fwd_mem = b;
      2'b10:   i_fwd_wb = b;
      default: i_read_data_2 = b;
    endcase
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b0; i_valid = 1'b1; i_md_op = OP_MULT; i_ctrl_wb_bus = 2'b11;
    i_ctrl_mem_bus = 9'h1FF; i_read_data_1 = 32'h1234; i_PC = 32'h40;
    step(); step();
    vectors++;
    if ({o_valid, o_PC_branch, o_ALU_result, o_write_data, o_write_register, o_ALU_zero,
         o_ctrl_wb_bus, o_ctrl_mem_bus, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b pc=%h res=%h wd=%h wr=%h z=%b wb=%h m=%h busy=%b exp all 0",
               o_valid, o_PC_branch, o_ALU_result, o_write_data, o_write_register, o_ALU_zero,
               o_ctrl_wb_bus, o_ctrl_mem_bus, o_busy);
    end
    idle_inputs();
    #1;
    vectors++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b exp 0", o_stall);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] a, b, exp_res;
    idle_inputs();
    i_valid = 1'b1; i_read_data_1 = 32'd9; i_fwd_mem = 32'd5; i_fwd_a = 2'b01;
    i_alu_ctl = 4'b0010; i_alu_src = 1'b1; i_imm_ext = 32'd3;
    step();
    vectors++;
    if ({o_ALU_result, o_ALU_zero, o_valid} !== {32'd8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL fwd_directed got res=%h z=%b v=%b exp res=8 z=0 v=1",
                         o_ALU_result, o_ALU_zero, o_valid);
    end
    for (int i = 0; i < 28; i++) begin
      case (i % 7)
        0: i_alu_ctl = 4'b0000;
        1: i_alu_ctl = 4'b0001;
        2: i_alu_ctl = 4'b0010;
        3: i_alu_ctl = 4'b0110;
        4: i_alu_ctl = 4'b0111;
        5: i_alu_ctl = 4'b1100;
        default: i_alu_ctl = 4'($urandom_range(0, 15));
      endcase
      i_fwd_a = 2'($urandom_range(0, 3)); i_fwd_b = 2'($urandom_range(0, 3));
      i_read_data_1 = $urandom; i_read_data_2 = $urandom; i_fwd_mem = $urandom; i_fwd_wb = $urandom;
      if ($urandom_range(0, 3) == 0) i_fwd_wb = i_fwd_mem;
      if ($urandom_range(0, 3) == 0) i_read_data_2 = i_read_data_1;
      i_imm_ext = $urandom; i_alu_src = 1'($urandom_range(0, 1)); i_reg_dst = 1'($urandom_range(0, 1));
      i_PC = $urandom; i_rt = 5'($urandom); i_rd = 5'($urandom);
      i_ctrl_wb_bus = 2'($urandom); i_ctrl_mem_bus = 9'($urandom);
      a = fwd_sel(i_fwd_a, i_read_data_1, i_fwd_mem, i_fwd_wb);
      b = fwd_sel(i_fwd_b, i_read_data_2, i_fwd_mem, i_fwd_wb);
      exp_res = alu_ref(i_alu_ctl, a, i_alu_src ? i_imm_ext : b);
      step();
      vectors++;
      if ({o_ALU_result, o_ALU_zero, o_valid} !== {exp_res, exp_res == 0, 1'b1}) begin
        errors++; $display("FAIL alu_%0d got res=%h z=%b v=%b exp res=%h z=%b v=1",
                           i, o_ALU_result, o_ALU_zero, o_valid, exp_res, exp_res == 0);
      end
      vectors++;
      if ({o_PC_branch, o_write_data, o_write_register, o_ctrl_wb_bus, o_ctrl_mem_bus} !==
          {i_PC + (i_imm_ext << 2), b, (i_reg_dst ? i_rd : i_rt), i_ctrl_wb_bus, i_ctrl_mem_bus}) begin
        errors++; $display("FAIL exmem_%0d got pc=%h wd=%h wr=%h wb=%h m=%h exp pc=%h wd=%h",
                           i, o_PC_branch, o_write_data, o_write_register, o_ctrl_wb_bus,
                           o_ctrl_mem_bus, i_PC + (i_imm_ext << 2), b);
      end
    end
    idle_inputs();
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, b, input bit add_during);
    logic [63:0] exp;
    logic [31:0] x, y;
    int exp_busy, cnt, gap;
    exp = md_ref(op, a, b);
    exp_busy = md_busy(op, b);
    idle_inputs();
    i_valid = 1'b1; i_md_op = op;
    drive_ops(a, b);
    step();
    vectors++;
    if ({o_busy, o_valid, o_ALU_result, o_ALU_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      errors++; $display("FAIL md_issue op=%0d got busy=%b v=%b res=%h z=%b exp busy=1 v=1 res=0 z=1",
                         op, o_busy, o_valid, o_ALU_result, o_ALU_zero);
    end
    gap = 0;
    if (add_during) begin
      x = $urandom; y = $urandom;
      idle_inputs();
      i_valid = 1'b1; i_alu_ctl = 4'b0010; i_read_data_1 = x; i_read_data_2 = y;
      #1;
      vectors++;
      if (o_stall !== 1'b0) begin
        errors++; $display("FAIL add_during_busy_stall got %b exp 0", o_stall);
      end
      step();
      vectors++;
      if ({o_valid, o_ALU_result} !== {1'b1, x + y}) begin
        errors++; $display("FAIL add_during_busy got v=%b res=%h exp v=1 res=%h", o_valid, o_ALU_result, x + y);
      end
      gap = 1;
    end
    idle_inputs();
    i_valid = 1'b1; i_md_op = OP_MFHI;
    #1;
    cnt = 0;
    while (o_stall === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    vectors++;
    if (cnt != exp_busy - gap) begin
      errors++; $display("FAIL md_stall_cycles op=%0d got %0d exp %0d", op, cnt, exp_busy - gap);
    end
    step();
    vectors++;
    if ({o_valid, o_ALU_result} !== {1'b1, exp[63:32]}) begin
      errors++; $display("FAIL mfhi op=%0d a=%h b=%h got %h exp %h", op, a, b, o_ALU_result, exp[63:32]);
    end
    i_md_op = OP_MFLO;
    step();
    vectors++;
    if ({o_valid, o_ALU_result} !== {1'b1, exp[31:0]}) begin
      errors++; $display("FAIL mflo op=%0d a=%h b=%h got %h exp %h", op, a, b, o_ALU_result, exp[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_muldiv();
    logic [2:0] op;
    logic [31:0] a, b;
    run_md(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_md(OP_DIVU, 32'h1234_5678, 32'd0, 1'b0);
    run_md(OP_MULTU, 32'd7, 32'd3, 1'b0);
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_md(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      run_md(op, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_mt();
    logic [31:0] h, l;
    h = $urandom | 32'h1; l = $urandom | 32'h2;
    idle_inputs();
    i_valid = 1'b1; i_md_op = OP_MT; i_imm_ext = 32'd0; drive_ops(h, $urandom);
    step();
    i_imm_ext = 32'd1; drive_ops(l, $urandom);
    step();
    idle_inputs();
    i_valid = 1'b1; i_md_op = OP_MFHI;
    #1;
    vectors++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL mt_idle_stall got %b exp 0", o_stall);
    end
    step();
    vectors++;
    if (o_ALU_result !== h) begin
      errors++; $display("FAIL mthi got %h exp %h", o_ALU_result, h);
    end
    i_md_op = OP_MFLO;
    step();
    vectors++;
    if (o_ALU_result !== l) begin
      errors++; $display("FAIL mtlo got %h exp %h", o_ALU_result, l);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [31:0] held;
    idle_inputs();
    i_valid = 1'b1; i_alu_ctl = 4'b0010; i_read_data_1 = $urandom; i_read_data_2 = $urandom;
    i_ctrl_wb_bus = 2'b11; i_ctrl_mem_bus = 9'h155;
    held = i_read_data_1 + i_read_data_2;
    step();
    i_flush = 1'b1; i_read_data_1 = held + 32'd17;
    step();
    vectors++;
    if ({o_valid, o_ctrl_wb_bus, o_ctrl_mem_bus, o_ALU_result} !== {1'b0, 2'b00, 9'h000, held}) begin
      errors++; $display("FAIL flush_bubble got v=%b wb=%h m=%h res=%h exp v=0 wb=0 m=0 res=%h",
                         o_valid, o_ctrl_wb_bus, o_ctrl_mem_bus, o_ALU_result, held);
    end
    i_md_op = OP_MULT;
    step();
    vectors++;
    if ({o_busy, o_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_mult got busy=%b v=%b exp busy=0 v=0", o_busy, o_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    idle_inputs();
    i_valid = 1'b1; i_md_op = OP_MULTU; drive_ops($urandom, $urandom | 32'h8000_0000);
    step();
    idle_inputs();
    repeat (5) step();
    i_rst = 1'b0;
    step();
    vectors++;
    if ({o_busy, o_valid, o_ALU_result, o_ctrl_wb_bus, o_ctrl_mem_bus} !== '0) begin
      errors++; $display("FAIL reset_mid_run got busy=%b v=%b res=%h exp all 0", o_busy, o_valid, o_ALU_result);
    end
    i_rst = 1'b1; i_valid = 1'b1; i_md_op = OP_MFHI;
    step();
    vectors++;
    if ({o_valid, o_ALU_result} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL reset_hi got v=%b res=%h exp v=1 res=0", o_valid, o_ALU_result);
    end
    i_md_op = OP_MFLO;
    step();
    vectors++;
    if ({o_valid, o_ALU_result} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL reset_lo got v=%b res=%h exp v=1 res=0", o_valid, o_ALU_result);
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_forwarding();
    test_muldiv();
    test_mt();
    test_flush();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
